// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: word width, FSM state
// encodings and the decoder's instruction classes.
package pc_sequencer_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JUMP   = 3'd4,
        OP_CALL   = 3'd5,
        OP_RET    = 3'd6,
        OP_HALT   = 3'd7
    } opclass_t;

    // Control-flow classes retire in EXEC; everything else continues.
    function automatic logic is_ctrl_flow(input opclass_t op);
        return (op == OP_BRANCH) || (op == OP_JUMP) ||
               (op == OP_CALL)   || (op == OP_RET);
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address stack used by CALL/RET. Callers must not push when
// full or pop when empty; both are ignored here as a safeguard.
module pc_ret_stack
    import pc_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [WORD_W-1:0] i_din,
    output logic [WORD_W-1:0] o_top,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_count;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [PTR_W-1:0]  w_top_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_wr_idx  = r_count[PTR_W-1:0];
    assign w_top_idx = w_wr_idx - PTR_W'(1);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_top     = r_mem[w_top_idx];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty && !i_push;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + (PTR_W+1)'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: entries above the count are never read.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB and
// produces the next PC, including a return-address stack for CALL/RET.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          STACK_DEPTH  = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [2:0]  i_opclass,
    input  logic        i_branch_taken,
    input  logic [15:0] i_target,
    input  logic [15:0] i_pc_cur,
    output logic        o_pc_en,
    output logic [15:0] o_pc_next,
    output logic        o_ir_en,
    output logic [2:0]  o_stage,
    output logic        o_halted,
    output logic        o_stk_ovf,
    output logic        o_stk_unf
);

    state_t            r_state;
    opclass_t          r_op;
    logic              r_stk_ovf;
    logic              r_stk_unf;

    logic [WORD_W-1:0] w_pc_inc;
    logic [WORD_W-1:0] w_stk_top;
    logic              w_stk_full;
    logic              w_stk_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_retire;

    assign w_pc_inc = i_pc_cur + 16'd1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_FETCH;
            r_op      <= OP_ALU;
            r_stk_ovf <= 1'b0;
            r_stk_unf <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_op    <= opclass_t'(i_opclass);
                    r_state <= (opclass_t'(i_opclass) == OP_HALT) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_op == OP_CALL && w_stk_full) begin
                        r_stk_ovf <= 1'b1;
                    end
                    if (r_op == OP_RET && w_stk_empty) begin
                        r_stk_unf <= 1'b1;
                    end
                    if (is_ctrl_flow(r_op)) begin
                        r_state <= ST_FETCH;
                    end else if (r_op == OP_LOAD || r_op == OP_STORE) begin
                        r_state <= ST_MEM;
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    r_state <= (r_op == OP_LOAD) ? ST_WB : ST_FETCH;
                end
                ST_WB: begin
                    r_state <= ST_FETCH;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // An instruction retires (and loads the PC) in the last state of its path.
    assign w_retire = ((r_state == ST_EXEC) && is_ctrl_flow(r_op)) ||
                      ((r_state == ST_MEM)  && (r_op == OP_STORE)) ||
                      (r_state == ST_WB);

    assign w_push = (r_state == ST_EXEC) && (r_op == OP_CALL) && !w_stk_full;
    assign w_pop  = (r_state == ST_EXEC) && (r_op == OP_RET)  && !w_stk_empty;

    always_comb begin
        o_pc_next = w_pc_inc;
        if (i_reset) begin
            o_pc_next = RESET_VECTOR;
        end else begin
            case (r_op)
                OP_BRANCH: o_pc_next = i_branch_taken ? i_target : w_pc_inc;
                OP_JUMP:   o_pc_next = i_target;
                OP_CALL:   o_pc_next = i_target;
                OP_RET:    o_pc_next = w_stk_empty ? w_pc_inc : w_stk_top;
                default:   o_pc_next = w_pc_inc;
            endcase
        end
    end

    // Reset forces a PC load every edge so the PC register takes the vector.
    assign o_pc_en   = i_reset | w_retire;
    assign o_ir_en   = (r_state == ST_FETCH) && !i_reset;
    assign o_halted  = (r_state == ST_HALT);
    assign o_stage   = r_state;
    assign o_stk_ovf = r_stk_ovf;
    assign o_stk_unf = r_stk_unf;

    pc_ret_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_pc_inc),
        .o_top   (w_stk_top),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a reference model predicts the
// retiring PC and latency of each instruction into a scoreboard queue.
module tb_pc_sequencer;

    typedef struct {
        logic [15:0] nextPc;
        int          cycle;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [2:0]  opclass;
    logic        branchTaken;
    logic [15:0] target;
    logic [15:0] pcCur;
    logic        pcEn;
    logic [15:0] pcNext;
    logic        irEn;
    logic [2:0]  stage;
    logic        halted;
    logic        stkOvf;
    logic        stkUnf;

    exp_t        scoreQ[$];
    logic [15:0] modelStack[$];
    logic        modelOvf;
    logic        modelUnf;
    int          checkCount;
    int          errorCount;

    pc_sequencer #(
        .RESET_VECTOR (16'h0040),
        .STACK_DEPTH  (8)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_opclass      (opclass),
        .i_branch_taken (branchTaken),
        .i_target       (target),
        .i_pc_cur       (pcCur),
        .o_pc_en        (pcEn),
        .o_pc_next      (pcNext),
        .o_ir_en        (irEn),
        .o_stage        (stage),
        .o_halted       (halted),
        .o_stk_ovf      (stkOvf),
        .o_stk_unf      (stkUnf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Holds reset across two edges, checking the vector load while asserted.
    task automatic applyReset();
        reset = 1'b1;
        #1;
        @(negedge clk);
        checkOutput("rst_pcEn", pcEn, 1);
        checkOutput("rst_pcNext", pcNext, 16'h0040);
        checkOutput("rst_irEn", irEn, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_stage", stage, 0);
        checkOutput("rst_ovf", stkOvf, 0);
        checkOutput("rst_unf", stkUnf, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_pcNext2", pcNext, 16'h0040);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelStack.delete();
        modelOvf = 1'b0;
        modelUnf = 1'b0;
    endtask

    // Runs one instruction from FETCH; entered and left just after a rising edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] pc, input logic [15:0] tgt,
                                 input logic taken, input string tag);
        logic [15:0] pcInc;
        logic [15:0] expNext;
        int          lat;
        exp_t        e;
        pcInc   = pc + 16'd1;
        expNext = pcInc;
        lat     = 3;
        case (op)
            3'd0: lat = 4;
            3'd1: lat = 5;
            3'd2: lat = 4;
            3'd3: expNext = taken ? tgt : pcInc;
            3'd4: expNext = tgt;
            3'd5: begin
                expNext = tgt;
                if (modelStack.size() < 8) modelStack.push_back(pcInc);
                else modelOvf = 1'b1;
            end
            3'd6: begin
                if (modelStack.size() > 0) expNext = modelStack.pop_back();
                else modelUnf = 1'b1;
            end
            default: lat = 3;
        endcase
        scoreQ.push_back('{expNext, lat});
        opclass     = op;
        pcCur       = pc;
        target      = tgt;
        branchTaken = taken;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput({tag, "_irEn"}, irEn, 1);
                checkOutput({tag, "_fetchStage"}, stage, 0);
            end
            if (pcEn) begin
                if (scoreQ.size() == 0) begin
                    checkOutput({tag, "_pcEnExtra"}, 1, 0);
                end else begin
                    e = scoreQ.pop_front();
                    checkOutput({tag, "_pcNext"}, pcNext, e.nextPc);
                    checkOutput({tag, "_pcEnCycle"}, k, e.cycle);
                end
            end
            @(posedge clk);
        end
        #1;
        if (scoreQ.size() != 0) begin
            checkOutput({tag, "_pcEnMissing"}, 0, 1);
            scoreQ.delete();
        end
        checkOutput({tag, "_nextStage"}, stage, 0);
        checkOutput({tag, "_ovf"}, stkOvf, modelOvf);
        checkOutput({tag, "_unf"}, stkUnf, modelUnf);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        reset       = 1'b1;
        opclass     = 3'd0;
        branchTaken = 1'b0;
        target      = 16'h0000;
        pcCur       = 16'h0000;
        modelOvf    = 1'b0;
        modelUnf    = 1'b0;

        applyReset();

        applyStimulus(3'd0, 16'h0010, 16'h0000, 1'b0, "alu");
        applyStimulus(3'd3, 16'h0050, 16'h0100, 1'b1, "brTaken");
        applyStimulus(3'd3, 16'h0100, 16'h0300, 1'b0, "brNotTaken");
        applyStimulus(3'd4, 16'h0005, 16'h1234, 1'b0, "jump");
        applyStimulus(3'd1, 16'h0030, 16'h0000, 1'b0, "load");
        applyStimulus(3'd2, 16'h0031, 16'h0000, 1'b0, "store");
        applyStimulus(3'd0, 16'hFFFF, 16'h0000, 1'b0, "aluWrap");

        applyStimulus(3'd5, 16'h0020, 16'h0200, 1'b0, "call");
        applyStimulus(3'd6, 16'h0200, 16'h0000, 1'b0, "ret");
        applyStimulus(3'd6, 16'hFFFF, 16'h0000, 1'b0, "retEmpty");

        applyReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(3'd5, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0, $sformatf("nestCall%0d", i));
        end
        for (int i = 0; i < 9; i++) begin
            applyStimulus(3'd6, 16'h3000, 16'h0000, 1'b0, $sformatf("nestRet%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            applyStimulus(3'($urandom_range(0, 6)), 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        // Abandon a LOAD in MEM with an asynchronous reset.
        applyStimulus(3'd5, 16'h0077, 16'h0500, 1'b0, "preCall");
        opclass = 3'd1;
        pcCur   = 16'h0500;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("midLoad_stage", stage, 3);
        checkOutput("midLoad_pcEn", pcEn, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRst_stage", stage, 0);
        checkOutput("midRst_pcEn", pcEn, 1);
        checkOutput("midRst_pcNext", pcNext, 16'h0040);
        checkOutput("midRst_irEn", irEn, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelStack.delete();
        modelOvf = 1'b0;
        modelUnf = 1'b0;
        applyStimulus(3'd6, 16'h0600, 16'h0000, 1'b0, "retAfterRst");
        applyStimulus(3'd0, 16'h0700, 16'h0000, 1'b0, "aluAfterRst");

        opclass = 3'd7;
        pcCur   = 16'h0800;
        @(negedge clk);
        checkOutput("halt_irEn", irEn, 1);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("halt_halted%0d", i), halted, 1);
            checkOutput($sformatf("halt_pcEn%0d", i), pcEn, 0);
            checkOutput($sformatf("halt_stage%0d", i), stage, 5);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 16'h0000, PC value loaded during reset.
REQ-002 Parameter STACK_DEPTH, default 8, return-address stack entries (power of 2, 2..16).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 opclass  input  3  instruction class from decoder: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 CALL, 6 RET, 7 HALT; sampled in DECODE.
REQ-006 branch_taken  input  1  branch condition; valid in EXEC.
REQ-007 target  input  16  branch/jump/call target; valid in EXEC.
REQ-008 pc_cur  input  16  current PC (PC register output).
REQ-009 pc_en  output  1  PC register load enable.
REQ-010 pc_next  output  16  PC register data input.
REQ-011 ir_en  output  1  instruction register load enable.
REQ-012 stage  output  3  current state encoding.
REQ-013 halted  output  1  high in HALT state.
REQ-014 stk_ovf  output  1  sticky stack overflow flag.
REQ-015 stk_unf  output  1  sticky stack underflow flag.

Function
REQ-016 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; the FSM follows one path per instruction.
REQ-017 FETCH: ir_en=1 for one cycle -> DECODE.
REQ-018 DECODE: opclass latched into internal register -> EXEC (HALT class -> HALT).
REQ-019 EXEC: BRANCH/JUMP/CALL/RET -> FETCH; ALU -> WB; LOAD/STORE -> MEM.
REQ-020 MEM: LOAD -> WB; STORE -> FETCH. WB -> FETCH.
REQ-021 HALT is terminal; exit only via reset.
REQ-022 pc_en SHALL be high exactly one cycle per instruction, in its final state (EXEC for control flow, MEM for STORE, WB for ALU/LOAD); never in FETCH, DECODE or HALT.
REQ-023 pc_next is combinational from latched opclass, pc_cur, target, branch_taken, stack top.
REQ-024 Sequential pc_next = pc_cur+1, modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-025 BRANCH: target if branch_taken, else pc_cur+1. JUMP: target.
REQ-026 CALL: push pc_cur+1, pc_next=target. RET: pop, pc_next = popped value.
REQ-027 CALL with stack full: no push, stk_ovf set, pc_next=target.
REQ-028 RET with stack empty: no pop, stk_unf set, pc_next=pc_cur+1.
REQ-029 Push/pop occur only on the pc_en cycle of CALL/RET; at most one stack operation per cycle.
REQ-030 ir_en, pc_en, halted are Moore outputs of state (plus latched opclass); no combinational path from inputs to pc_en.
REQ-031 Instruction latencies: control flow 3 cycles, STORE 4, ALU 4, LOAD 5.

Reset
REQ-032 While reset is high: state=FETCH, stack empty, stk_ovf=stk_unf=0, ir_en=0, halted=0, stage=0.
REQ-033 While reset is high: pc_en=1 and pc_next=RESET_VECTOR, so the PC loads the vector on every edge during reset.
REQ-034 Reset asserted mid-instruction SHALL abandon it immediately with no stack change; first cycle after deassertion is FETCH.

Structure
REQ-035 Shared package holds state encodings, opclass codes, and 16-bit word width constant.
REQ-036 Return stack SHALL be sub-module pc_ret_stack (push, pop, din, top, full, empty; async reset).

Verification
REQ-037 Reset held 2 edges, RESET_VECTOR=16'h0040 -> PC=16'h0040; after release FETCH with ir_en=1, pc_en=0.
REQ-038 ALU, pc_cur=16'h0010 -> pc_en only in WB, pc_next=16'h0011, next instruction FETCH on cycle 5.
REQ-039 BRANCH taken target=16'h0100, then not taken at pc_cur=16'h0100 -> pc_next 16'h0100, then 16'h0101; pc_en in EXEC each.
REQ-040 CALL at 16'h0020 to 16'h0200, RET -> pc_next 16'h0200 then 16'h0021; 9 nested CALLs (depth 8) -> stk_ovf=1 on ninth.
REQ-041 RET on empty stack at pc_cur=16'hFFFF -> stk_unf=1, pc_next=16'h0000 (wrap).
REQ-042 HALT opclass -> halted=1, pc_en=0 indefinitely; reset mid-LOAD in MEM -> FETCH, stack unchanged.
